// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared constants and helpers for the digit-serial BCD adder:
//               FSM state encoding, BCD digit width/limit, counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // FSM state encoding
    localparam int          STATE_W = 2;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_RUN  = 2'd1;
    localparam logic [1:0]  ST_DONE = 2'd2;

    // BCD digit properties
    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX     = 4'd9;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_adder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_adder
// Description : Single-digit BCD adder slice: s/Cout = a + b + Cin with
//               decimal correction when the binary sum exceeds nine.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_adder
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       Cin,
    output logic [3:0] s,
    output logic       Cout
);

    logic [4:0] w_bin;

    assign w_bin = {1'b0, a} + {1'b0, b} + {4'b0000, Cin};

    // Add six to wrap a binary result above nine back into BCD range
    always_comb begin
        s    = w_bin[3:0];
        Cout = 1'b0;
        if (w_bin > {1'b0, BCD_MAX}) begin
            s    = w_bin[3:0] + 4'd6;
            Cout = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_adder
// Description : Digit-serial packed-BCD adder. Operands are accepted over a
//               valid/ready handshake, summed one digit per clock (LSD first)
//               through a single bcd_adder slice, and the result is returned
//               over a second valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*NUM_DIGITS-1:0]   a,
    input  logic [4*NUM_DIGITS-1:0]   b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*NUM_DIGITS-1:0]   sum,
    output logic                      cout,
    output logic                      err
);

    localparam int DW    = BCD_DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = clog2_min1(NUM_DIGITS);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               r_rdy_en;
    logic [DW-1:0]      r_a;
    logic [DW-1:0]      r_b;
    logic [DW-1:0]      r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [3:0]         w_a_dig;
    logic [3:0]         w_b_dig;
    logic [3:0]         w_s;
    logic               w_cout;
    logic               w_accept;
    logic               w_last;
    logic               w_dig_bad;
    logic [DW+3:0]      w_sum_shift;

    assign w_a_dig     = r_a[3:0];
    assign w_b_dig     = r_b[3:0];
    assign w_accept    = (r_state == ST_IDLE) && r_rdy_en && in_valid;
    assign w_last      = (r_cnt == c_LAST_CNT);
    assign w_dig_bad   = (w_a_dig > BCD_MAX) || (w_b_dig > BCD_MAX);
    // New digit enters at the top; shifting the concatenation keeps this
    // legal even when the sum register is a single digit wide
    assign w_sum_shift = {w_s, r_sum} >> BCD_DIGIT_W;

    bcd_adder u_bcd_adder (
        .a    (w_a_dig),
        .b    (w_b_dig),
        .Cin  (r_carry),
        .s    (w_s),
        .Cout (w_cout)
    );

    // State register; r_rdy_en keeps in_ready low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_rdy_en <= 1'b1;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on last digit, DONE -> IDLE on handoff
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_next_state = ST_RUN;
            ST_RUN:  if (w_last)    w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from registered state
    always_comb begin
        in_ready  = (r_state == ST_IDLE) && r_rdy_en;
        out_valid = (r_state == ST_DONE);
    end

    // Datapath: operand capture, digit-serial shift/add, carry and error tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_err   <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == ST_RUN) begin
                r_a     <= r_a >> BCD_DIGIT_W;
                r_b     <= r_b >> BCD_DIGIT_W;
                r_sum   <= w_sum_shift[DW-1:0];
                r_carry <= w_cout;
                r_err   <= r_err | w_dig_bad;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) begin
                    r_cout <= w_cout;
                end
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_adder
// Description : Scoreboard bench for bcd_serial_adder with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_adder;

    localparam int ND = 4;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
        logic        chk_sum;
        int          acc;
        logic        lat_done;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int   cyc;
    int   checks;
    int   passes;
    exp_t q[$];
    logic prev_ov;

    bcd_serial_adder #(.NUM_DIGITS(ND)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: latency on out_valid rise, result compare on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_ov && q.size() != 0 && !q[0].lat_done) begin
                chk("latency", 32'(cyc - q[0].acc), 32'(ND));
                q[0].lat_done = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.chk_sum) begin
                        chk("sum", 32'(sum), 32'(e.sum));
                        chk("cout", 32'(cout), 32'(e.cout));
                    end
                    chk("err", 32'(err), 32'(e.err));
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic [15:0] es, input logic ec, input logic ee,
                        input logic chk_sum);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(0), 32'(1));
        end else begin
            a = ta; b = tb_; cin = tc; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            e.sum = es; e.cout = ec; e.err = ee; e.chk_sum = chk_sum;
            e.acc = cyc; e.lat_done = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            chk("result_timeout", 32'(q.size()), 32'(0));
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        cyc = 0; checks = 0; passes = 0; prev_ov = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        #23;
        chk("rst_in_ready",  32'(in_ready),  32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum",       32'(sum),       32'(0));
        chk("rst_cout",      32'(cout),      32'(0));
        chk("rst_err",       32'(err),       32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'(1));

        // Directed vectors
        send(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1); drain();
        send(16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1); drain();
        send(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1); drain();
        send(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); drain();
        send(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); drain();
        send(16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); drain();
        send(16'h0909, 16'h0191, 1'b0, 16'h1100, 1'b0, 1'b0, 1'b1); drain();
        send(16'h0000, 16'hB000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); drain();

        // Back-pressure: hold result while inputs toggle
        out_ready = 1'b0;
        send(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid_rise", 32'(out_valid), 32'(1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'(1));
            chk("bp_sum",       32'(sum),       32'(16'h5432));
            chk("bp_cout",      32'(cout),      32'(0));
            chk("bp_in_ready",  32'(in_ready),  32'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        send(16'h0456, 16'h0544, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1); drain();

        // Reset mid-RUN: no result may emerge
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        a = 16'h9999; b = 16'h9999; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_sum",       32'(sum),       32'(0));
        chk("midrst_cout",      32'(cout),      32'(0));
        chk("midrst_err",       32'(err),       32'(0));
        chk("midrst_in_ready",  32'(in_ready),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_no_result", 32'(out_valid), 32'(0));
            if (out_valid) break;
        end
        send(16'h0001, 16'h0009, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1); drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
